// File: rtl/soc_bus_fabric.sv
// soc_bus_fabric: single-master bus fabric. It decodes the master address
// against NUM_SLAVES base/size windows, drives one-hot slave strobes and a
// window-relative address, and returns read data in order through a tracker
// of up to MAX_OUTSTANDING reads. Unmapped accesses and timed-out reads
// produce error responses. The first faulting address is captured.
// Ports:
//   clk, reset (async active-low)
//   address/read/write                    master request
//   waitRequest                           master stall
//   readValid/dataIn/busError             read response
//   slaveRead/slaveWrite/slaveAddress     slave-side request
//   slaveWaitRequest/slaveValid/slaveData slave-side status and data
//   errorIrq/errorAddress/errorClear      sticky fault capture
module soc_bus_fabric #(
  parameter int unsigned                 NUM_SLAVES      = 10,
  parameter logic [NUM_SLAVES*32-1:0]    ADDR_BASE       = '0,
  parameter logic [NUM_SLAVES*32-1:0]    ADDR_SIZE       = '0,
  parameter int unsigned                 MAX_OUTSTANDING = 4,
  parameter int unsigned                 TIMEOUT         = 255,
  parameter logic [31:0]                 ERROR_DATA      = 32'h0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  address,
  input  logic                         read,
  input  logic                         write,
  output logic                         waitRequest,
  output logic                         readValid,
  output logic [31:0]                  dataIn,
  output logic                         busError,
  output logic [NUM_SLAVES-1:0]        slaveRead,
  output logic [NUM_SLAVES-1:0]        slaveWrite,
  output logic [31:0]                  slaveAddress,
  input  logic [NUM_SLAVES-1:0]        slaveWaitRequest,
  input  logic [NUM_SLAVES-1:0]        slaveValid,
  input  logic [NUM_SLAVES*32-1:0]     slaveData,
  output logic                         errorIrq,
  output logic [31:0]                  errorAddress,
  input  logic                         errorClear
);

  localparam int unsigned IDW = $clog2(NUM_SLAVES + 1);
  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned WW  = $clog2(TIMEOUT + 1);
  localparam logic [IDW-1:0] DEF_ID = IDW'(NUM_SLAVES);

  logic [IDW-1:0] r_fifo_id   [MAX_OUTSTANDING];
  logic [31:0]    r_fifo_addr [MAX_OUTSTANDING];
  logic [PW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic [WW-1:0]  r_wait_cnt;
  logic           r_err_arm;

  logic           w_hit;
  logic [IDW-1:0] w_sel;
  logic [31:0]    w_base;
  logic           w_rd_acc, w_wr_acc, w_push, w_pop;
  logic           w_empty, w_head_real, w_def_head, w_timeout;
  logic [IDW-1:0] w_head_id;
  logic [31:0]    w_head_addr;
  logic           w_head_valid;
  logic [31:0]    w_head_data;
  logic           w_ok_resp, w_err_resp;
  logic           w_fault;
  logic [31:0]    w_fault_addr;

  // Address decode; descending scan so the lowest matching index wins.
  // 33-bit compare keeps a window ending at 4 GiB from wrapping.
  always_comb begin
    w_hit  = 1'b0;
    w_sel  = DEF_ID;
    w_base = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (({1'b0, address} >= {1'b0, ADDR_BASE[32*i +: 32]}) &&
          ({1'b0, address} <  ({1'b0, ADDR_BASE[32*i +: 32]} + {1'b0, ADDR_SIZE[32*i +: 32]}))) begin
        w_hit  = 1'b1;
        w_sel  = IDW'(i);
        w_base = ADDR_BASE[32*i +: 32];
      end
    end
  end

  // Master handshake and slave strobes; the full test uses the registered count.
  always_comb begin
    waitRequest  = (w_hit && slaveWaitRequest[w_sel]) ||
                   (read && (r_count == CW'(MAX_OUTSTANDING)));
    w_rd_acc     = read  && !waitRequest;
    w_wr_acc     = write && !waitRequest;
    slaveRead    = (w_rd_acc && w_hit) ? (NUM_SLAVES'(1) << w_sel) : '0;
    slaveWrite   = (w_wr_acc && w_hit) ? (NUM_SLAVES'(1) << w_sel) : '0;
    slaveAddress = w_hit ? (address - w_base) : address;
  end

  // Head-of-tracker lookup of the selected slave's valid and data.
  always_comb begin
    w_head_id    = r_fifo_id[r_rd_ptr];
    w_head_addr  = r_fifo_addr[r_rd_ptr];
    w_head_valid = 1'b0;
    w_head_data  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (w_head_id == IDW'(i)) begin
        w_head_valid = slaveValid[i];
        w_head_data  = slaveData[32*i +: 32];
      end
    end
  end

  // Response selection; a pending error response has priority over slave data.
  always_comb begin
    w_empty     = (r_count == '0);
    w_head_real = !w_empty && (w_head_id != DEF_ID);
    w_def_head  = !w_empty && (w_head_id == DEF_ID);
    w_timeout   = w_head_real && (r_wait_cnt == WW'(TIMEOUT - 1));
    w_err_resp  = r_err_arm;
    w_ok_resp   = !r_err_arm && w_head_real && w_head_valid;
    readValid   = w_err_resp || w_ok_resp;
    busError    = w_err_resp;
    dataIn      = w_err_resp ? ERROR_DATA : (w_ok_resp ? w_head_data : '0);
    w_push      = w_rd_acc;
    w_pop       = readValid;
  end

  // Fault sources; a timeout reports the older, stored address first.
  always_comb begin
    w_fault      = ((w_rd_acc || w_wr_acc) && !w_hit) || (w_err_resp && w_head_real);
    w_fault_addr = (w_err_resp && w_head_real) ? w_head_addr : address;
  end

  // Tracker pointers, occupancy, wait counter and error-response arming.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_wait_cnt <= '0;
      r_err_arm  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_pop || w_empty) begin
        r_wait_cnt <= '0;
      end else if (w_head_real) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      // Arming only when the head stays put makes the error response one
      // cycle after the entry becomes head, or after the timeout is reached.
      r_err_arm <= !w_pop && (w_def_head || w_timeout);
    end
  end

  // Tracker storage: slave ID plus request address for timeout reporting.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_id[r_wr_ptr]   <= w_sel;
      r_fifo_addr[r_wr_ptr] <= address;
    end
  end

  // Sticky fault capture; clear wins over a same-cycle capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      errorIrq     <= 1'b0;
      errorAddress <= '0;
    end else if (errorClear) begin
      errorIrq     <= 1'b0;
      errorAddress <= '0;
    end else if (w_fault && !errorIrq) begin
      errorIrq     <= 1'b1;
      errorAddress <= w_fault_addr;
    end
  end

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Directed bench for soc_bus_fabric: decode, in-order returns, tracker
// stall, unmapped and timeout errors, fault capture, reset flush, overlap.
module tb_soc_bus_fabric;

  localparam int unsigned NS = 6;
  localparam logic [NS*32-1:0] BASES = {32'h0000_A080, 32'h0000_C000, 32'h0000_4010,
                                        32'h0000_A000, 32'h0000_8000, 32'h0000_0000};
  localparam logic [NS*32-1:0] SIZES = {32'h0000_0100, 32'h0000_0040, 32'h0000_0010,
                                        32'h0000_0100, 32'h0000_0100, 32'h0000_4000};
  localparam logic [31:0] ERR_D = 32'hDEAD_BEEF;

  logic            clk = 1'b0;
  logic            reset;
  logic [31:0]     address;
  logic            read, write;
  logic            waitRequest, readValid, busError;
  logic [31:0]     dataIn;
  logic [NS-1:0]   slaveRead, slaveWrite;
  logic [31:0]     slaveAddress;
  logic [NS-1:0]   slaveWaitRequest, slaveValid;
  logic [NS*32-1:0] slaveData;
  logic            errorIrq, errorClear;
  logic [31:0]     errorAddress;

  int n_tests = 0;
  int n_fail  = 0;

  soc_bus_fabric #(
    .NUM_SLAVES(NS), .ADDR_BASE(BASES), .ADDR_SIZE(SIZES),
    .MAX_OUTSTANDING(4), .TIMEOUT(16), .ERROR_DATA(ERR_D)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .waitRequest(waitRequest), .readValid(readValid), .dataIn(dataIn),
    .busError(busError), .slaveRead(slaveRead), .slaveWrite(slaveWrite),
    .slaveAddress(slaveAddress), .slaveWaitRequest(slaveWaitRequest),
    .slaveValid(slaveValid), .slaveData(slaveData), .errorIrq(errorIrq),
    .errorAddress(errorAddress), .errorClear(errorClear)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_data(input int idx, input logic [31:0] val);
    slaveData[32*idx +: 32] = val;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;
    reset = 1'b0; address = '0; read = 1'b0; write = 1'b0;
    slaveWaitRequest = '0; slaveValid = '0; slaveData = '0; errorClear = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_rvalid", 32'(readValid), 32'd0);
    chk("rst_berr",   32'(busError), 32'd0);
    chk("rst_irq",    32'(errorIrq), 32'd0);
    chk("rst_eaddr",  errorAddress, 32'd0);
    chk("rst_count",  32'(dut.r_count), 32'd0);
    chk("rst_wait",   32'(waitRequest), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Basic decode and zero-latency return from slave3.
    read = 1'b1; address = 32'h4014; #2;
    chk("a_sread", 32'(slaveRead), 32'b001000);
    chk("a_saddr", slaveAddress, 32'h4);
    chk("a_wait",  32'(waitRequest), 32'd0);
    @(negedge clk);
    read = 1'b0; slaveValid = 6'b001000; set_data(3, 32'hCAFE); #2;
    chk("a_rvalid", 32'(readValid), 32'd1);
    chk("a_data",   dataIn, 32'hCAFE);
    chk("a_berr",   32'(busError), 32'd0);
    @(negedge clk);
    slaveValid = '0; #2;
    chk("a_idle", 32'(readValid), 32'd0);

    // Tracker fills at four; a pop releases the stall one cycle later.
    for (int i = 0; i < 4; i++) begin
      read = 1'b1; address = 32'(i * 4); #2;
      chk("b_nowait", 32'(waitRequest), 32'd0);
      @(negedge clk);
    end
    address = 32'h10; #2;
    chk("b_full",     32'(waitRequest), 32'd1);
    chk("b_nostrobe", 32'(slaveRead), 32'd0);
    slaveValid = 6'b000001; set_data(0, 32'h100); #2;
    chk("b_rv0",      32'(readValid), 32'd1);
    chk("b_d0",       dataIn, 32'h100);
    chk("b_stillful", 32'(waitRequest), 32'd1);
    @(negedge clk);
    slaveValid = '0; #2;
    chk("b_release", 32'(waitRequest), 32'd0);
    chk("b_strobe",  32'(slaveRead), 32'b000001);
    @(negedge clk);
    read = 1'b0;
    for (int i = 0; i < 4; i++) begin
      slaveValid = 6'b000001; set_data(0, 32'h101 + 32'(i)); #2;
      chk("b_rv", 32'(readValid), 32'd1);
      chk("b_d",  dataIn, 32'h101 + 32'(i));
      @(negedge clk);
    end
    slaveValid = '0; #2;
    chk("b_empty", 32'(dut.r_count), 32'd0);

    // Unmapped read: error response two cycles after accept.
    read = 1'b1; address = 32'h9000; #2;
    chk("c_nostrobe", 32'(slaveRead), 32'd0);
    chk("c_wait",     32'(waitRequest), 32'd0);
    @(negedge clk);
    read = 1'b0; #2;
    chk("c_t1", 32'(readValid), 32'd0);
    @(negedge clk); #2;
    chk("c_rv",    32'(readValid), 32'd1);
    chk("c_berr",  32'(busError), 32'd1);
    chk("c_data",  dataIn, ERR_D);
    chk("c_irq",   32'(errorIrq), 32'd1);
    chk("c_eaddr", errorAddress, 32'h9000);
    @(negedge clk); #2;
    chk("c_once", 32'(readValid), 32'd0);
    errorClear = 1'b1;
    @(negedge clk);
    errorClear = 1'b0; #2;
    chk("c_clr_irq", 32'(errorIrq), 32'd0);

    // Hung slave1: error response TIMEOUT+1 cycles after accept.
    read = 1'b1; address = 32'h8004; #2;
    chk("d_strobe", 32'(slaveRead), 32'b000010);
    @(negedge clk);
    read = 1'b0;
    lat = 1; seen = 1'b0;
    while (!seen && lat < 40) begin
      #2;
      if (readValid) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk("d_latency", 32'(lat), 32'd17);
    chk("d_berr",    32'(busError), 32'd1);
    chk("d_data",    dataIn, ERR_D);
    @(negedge clk);
    slaveValid = 6'b000010; set_data(1, 32'h7777); #2;
    chk("d_irq",   32'(errorIrq), 32'd1);
    chk("d_eaddr", errorAddress, 32'h8004);
    chk("d_late",  32'(readValid), 32'd0);
    @(negedge clk);
    slaveValid = '0; write = 1'b1; address = 32'h9100; #2;
    chk("d_wr_nostrobe", 32'(slaveWrite), 32'd0);
    @(negedge clk);
    write = 1'b0; #2;
    chk("d_keep_eaddr", errorAddress, 32'h8004);
    errorClear = 1'b1;
    @(negedge clk);
    errorClear = 1'b0; #2;
    chk("d_clr_irq",   32'(errorIrq), 32'd0);
    chk("d_clr_eaddr", errorAddress, 32'd0);

    // Out-of-order valid from a non-head slave is ignored.
    read = 1'b1; address = 32'h20;
    @(negedge clk);
    address = 32'h8008;
    @(negedge clk);
    read = 1'b0; slaveValid = 6'b000010; set_data(1, 32'h1111); #2;
    chk("e_stray", 32'(readValid), 32'd0);
    @(negedge clk);
    slaveValid = 6'b000001; set_data(0, 32'h2222); #2;
    chk("e_rv0", 32'(readValid), 32'd1);
    chk("e_d0",  dataIn, 32'h2222);
    @(negedge clk);
    slaveValid = 6'b000010; set_data(1, 32'h3333); #2;
    chk("e_rv1", 32'(readValid), 32'd1);
    chk("e_d1",  dataIn, 32'h3333);
    @(negedge clk);
    slaveValid = '0;

    // Reset with three reads pending flushes the tracker.
    read = 1'b1; address = 32'h30;
    repeat (3) @(negedge clk);
    read = 1'b0; reset = 1'b0; #2;
    chk("f_count", 32'(dut.r_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      slaveValid = 6'b000001; #2;
      chk("f_norv", 32'(readValid), 32'd0);
      @(negedge clk);
    end
    slaveValid = '0;

    // Overlapping windows: slave2 beats slave5; per-slave stall applies.
    read = 1'b1; address = 32'hA090; #2;
    chk("g_sread", 32'(slaveRead), 32'b000100);
    chk("g_saddr", slaveAddress, 32'h90);
    slaveWaitRequest = 6'b000100; #2;
    chk("g_swait",    32'(waitRequest), 32'd1);
    chk("g_nostrobe", 32'(slaveRead), 32'd0);
    slaveWaitRequest = '0;
    @(negedge clk);
    read = 1'b0; slaveValid = 6'b000100; set_data(2, 32'h5555); #2;
    chk("g_rv", 32'(readValid), 32'd1);
    chk("g_d",  dataIn, 32'h5555);
    @(negedge clk);
    slaveValid = '0;

    // Window edges via writes.
    write = 1'b1; address = 32'h401F; #2;
    chk("h_end_sw",  32'(slaveWrite), 32'b001000);
    chk("h_end_sa",  slaveAddress, 32'hF);
    @(negedge clk);
    address = 32'h4000; #2;
    chk("h_gap_sw",  32'(slaveWrite), 32'd0);
    chk("h_gap_sa",  slaveAddress, 32'h4000);
    @(negedge clk);
    address = 32'h3FFC; #2;
    chk("h_s0_sw",   32'(slaveWrite), 32'b000001);
    chk("h_s0_sa",   slaveAddress, 32'h3FFC);
    chk("h_eaddr",   errorAddress, 32'h4000);
    @(negedge clk);
    write = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
